// File: rtl/axi_pkg.sv
// Shared AXI response codes and FSM state encodings for the SRAM slave.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

  function automatic logic [1:0] resp_for(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/sram_sdp.sv
// Simple dual-port word RAM: one synchronous read port with a registered,
// enable-held output and one byte-enabled write port. Reads are read-first.
module sram_sdp #(
  parameter int ADDR_W    = 10,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [31:0] INIT_WORD = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

  logic [31:0] mem_q [DEPTH] = '{default: INIT_WORD};
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Output register only loads when the read port is enabled
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read register and byte-lane writes; nonblocking order gives old data on collision
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    for (int b = 0; b < 4; b++) begin
      if (we && wstrb[b]) begin
        mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave fronting a word SRAM: independent single-outstanding read and
// write FSMs, all bursts treated as INCR of 4-byte beats with aliased addresses.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int INIT_ZERO = 1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  r_state_e          r_state_q, r_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [3:0]        rid_q, rid_d;
  logic [3:0]        r_len_q, r_len_d;
  logic [3:0]        r_cnt_q, r_cnt_d;
  logic [ADDR_W-1:0] r_idx_q, r_idx_d;

  w_state_e          w_state_q, w_state_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [3:0]        bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [3:0]        w_len_q, w_len_d;
  logic [3:0]        w_cnt_q, w_cnt_d;
  logic [ADDR_W-1:0] w_idx_q, w_idx_d;
  logic              w_err_q, w_err_d;

  logic              ar_hs_s, r_hs_s, aw_hs_s, w_hs_s;
  logic              w_final_s, w_err_next_s;
  logic              ram_re_s, ram_we_s;
  logic [ADDR_W-1:0] ram_raddr_s;
  logic              unused_s;

  assign ar_hs_s      = arvalid & arready_q;
  assign r_hs_s       = rvalid_q & rready;
  assign aw_hs_s      = awvalid & awready_q;
  assign w_hs_s       = wvalid & wready_q;
  assign w_final_s    = (w_cnt_q == w_len_q);
  assign w_err_next_s = w_err_q | (wlast != w_final_s);

  // Burst type/size, the sub-word and aliased address bits, and wid carry no meaning here
  assign unused_s = ^{araddr[31:ADDR_W+2], araddr[1:0], arsize, arburst,
                      awaddr[31:ADDR_W+2], awaddr[1:0], awsize, awburst, wid};

  // Read FSM: next state, burst bookkeeping and RAM read-port control
  always_comb begin
    r_state_d   = r_state_q;
    rid_d       = rid_q;
    r_len_d     = r_len_q;
    r_cnt_d     = r_cnt_q;
    r_idx_d     = r_idx_q;
    ram_re_s    = 1'b0;
    ram_raddr_s = r_idx_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rid_d       = arid;
          r_len_d     = arlen;
          r_cnt_d     = 4'd0;
          r_idx_d     = araddr[ADDR_W+1:2];
          ram_re_s    = 1'b1;
          ram_raddr_s = araddr[ADDR_W+1:2];
          r_state_d   = R_DATA;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (r_hs_s && rlast_q) begin
          r_state_d = R_IDLE;
        end else if (r_hs_s) begin
          // Fetch the following word now so the next beat lands one cycle later
          r_cnt_d     = r_cnt_q + 4'd1;
          r_idx_d     = r_idx_q + ADDR_W'(1);
          ram_re_s    = 1'b1;
          ram_raddr_s = r_idx_q + ADDR_W'(1);
          r_state_d   = R_DATA;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rlast_d   = (r_state_d == R_DATA) && (r_cnt_d == r_len_d);
  end

  // Read FSM state and registered read-channel outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= 4'd0;
      r_len_q   <= 4'd0;
      r_cnt_q   <= 4'd0;
      r_idx_q   <= {ADDR_W{1'b0}};
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_idx_q   <= r_idx_d;
    end
  end

  // Write FSM: beat counting, wlast consistency and response selection
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_idx_d   = w_idx_q;
    w_err_d   = w_err_q;
    ram_we_s  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          bid_d     = awid;
          w_len_d   = awlen;
          w_idx_d   = awaddr[ADDR_W+1:2];
          w_cnt_d   = 4'd0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_hs_s) begin
          ram_we_s = 1'b1;
          w_idx_d  = w_idx_q + ADDR_W'(1);
          w_cnt_d  = w_cnt_q + 4'd1;
          w_err_d  = w_err_next_s;
          // awlen alone decides the burst end; a misplaced wlast only flags an error
          if (w_final_s) begin
            bresp_d   = resp_for(w_err_next_s);
            w_state_d = W_RESP;
          end else begin
            w_state_d = W_DATA;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write FSM state and registered write-channel outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= 4'd0;
      bresp_q   <= RESP_OKAY;
      w_len_q   <= 4'd0;
      w_cnt_q   <= 4'd0;
      w_idx_q   <= {ADDR_W{1'b0}};
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_idx_q   <= w_idx_d;
      w_err_q   <= w_err_d;
    end
  end

  sram_sdp #(
    .ADDR_W   (ADDR_W),
    .INIT_ZERO(INIT_ZERO)
  ) u_ram (
    .clk  (aclk),
    .re   (ram_re_s),
    .raddr(ram_raddr_s),
    .rdata(rdata),
    .we   (ram_we_s),
    .waddr(w_idx_q),
    .wstrb(wstrb),
    .wdata(wdata)
  );

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rresp   = RESP_OKAY;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized and directed bench for axi_sram_slave against a word-array model
// with expected-beat and expected-response queues checked every cycle.
module tb_axi_sram_slave;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
  } rbeat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bresp_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  arid, arlen, awid, awlen, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;
  logic        arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  axi_sram_slave #(.ADDR_W(ADDR_W), .INIT_ZERO(1)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model [DEPTH];
  rbeat_t      exp_r[$];
  rbeat_t      got[$];
  bresp_t      exp_b[$];
  bresp_t      got_b[$];
  logic [31:0] d [16];
  logic [3:0]  s [16];
  int          cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: visible read beat and write response must match the queue heads
  always @(negedge aclk) begin
    if (!areset) begin
      if (rvalid) begin
        if (exp_r.size() == 0) begin
          chk("r_unexpected", 32'(rvalid), 32'd0);
        end else begin
          chk("rdata", rdata, exp_r[0].data);
          chk("rid", 32'(rid), 32'(exp_r[0].id));
          chk("rlast", 32'(rlast), 32'(exp_r[0].last));
          chk("rresp", 32'(rresp), 32'd0);
          if (rready) begin
            got.push_back('{data: rdata, id: rid, last: rlast});
            void'(exp_r.pop_front());
          end
        end
      end
      if (bvalid) begin
        if (exp_b.size() == 0) begin
          chk("b_unexpected", 32'(bvalid), 32'd0);
        end else begin
          chk("bid", 32'(bid), 32'(exp_b[0].id));
          chk("bresp", 32'(bresp), 32'(exp_b[0].resp));
          if (bready) begin
            got_b.push_back('{id: bid, resp: bresp});
            void'(exp_b.pop_front());
          end
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input logic [31:0] data [16], input logic [3:0] strb [16],
                          input logic [15:0] lastm, input bit gaps);
    int   idx;
    int   n;
    logic err;
    idx = int'(addr[ADDR_W+1:2]);
    err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      int w;
      w = (idx + i) % DEPTH;
      for (int b = 0; b < 4; b++) begin
        if (strb[i][b]) model[w][8*b +: 8] = data[i][8*b +: 8];
      end
      if (lastm[i] != (i == int'(len))) err = 1'b1;
    end
    exp_b.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    awaddr = addr; awid = id; awlen = len; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(posedge aclk); #1; n++; end
    chk("aw_ready_wait", 32'(awready), 32'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(posedge aclk); #1;
      end
      wvalid = 1'b1; wdata = data[i]; wstrb = strb[i]; wlast = lastm[i]; wid = 4'($urandom);
      n = 0;
      while (!wready && n < 50) begin @(posedge aclk); #1; n++; end
      chk("w_ready_wait", 32'(wready), 32'd1);
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge aclk); #1; n++; end
    chk("b_valid_wait", 32'(bvalid), 32'd1);
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  // mode 0: rready held high, 1: toggles 1,0,1,0..., 2: random
  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                         input int mode, output int cycles);
    int idx;
    int n;
    idx = int'(addr[ADDR_W+1:2]);
    for (int i = 0; i <= int'(len); i++) begin
      exp_r.push_back('{data: model[(idx + i) % DEPTH], id: id, last: (i == int'(len))});
    end
    got.delete();
    araddr = addr; arid = id; arlen = len; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(posedge aclk); #1; n++; end
    chk("ar_ready_wait", 32'(arready), 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    chk("r_first_latency", 32'(rvalid), 32'd1);
    cycles = 0;
    while (got.size() < int'(len) + 1 && cycles < 400) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cycles % 2) == 0) : 1'($urandom_range(0, 1));
      @(posedge aclk); #1;
      cycles++;
    end
    rready = 1'b0;
    chk("r_beat_count", 32'(got.size()), 32'(int'(len) + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    arid = 4'd0; araddr = 32'd0; arlen = 4'd0; arsize = 3'd0; arburst = 2'd0; arvalid = 1'b0;
    rready = 1'b0; awid = 4'd0; awaddr = 32'd0; awlen = 4'd0; awsize = 3'd0; awburst = 2'd0;
    awvalid = 1'b0; wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0;
    for (int i = 0; i < 16; i++) begin d[i] = 32'd0; s[i] = 4'hF; end

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_ids", 32'({rid, bid}), 32'd0);
    chk("rst_resps", 32'({rresp, bresp}), 32'd0);
    areset = 1'b0;
    chk("rel_arready_low", 32'(arready), 32'd0);
    @(posedge aclk); #1;
    chk("rel_arready_high", 32'(arready), 32'd1);
    chk("rel_awready_high", 32'(awready), 32'd1);

    // single-beat write then read of 0x10
    d[0] = 32'hDEADBEEF;
    do_write(32'h10, 4'd0, 4'd5, d, s, 16'h0001, 1'b0);
    chk("t1_bid", 32'(got_b[$].id), 32'd5);
    chk("t1_bresp", 32'(got_b[$].resp), 32'd0);
    do_read(32'h10, 4'd0, 4'd3, 0, cyc);
    chk("t1_rdata", got[0].data, 32'hDEADBEEF);
    chk("t1_rid", 32'(got[0].id), 32'd3);
    chk("t1_rlast", 32'(got[0].last), 32'd1);

    // 4-beat burst at 0x100, full-rate read
    for (int i = 0; i < 4; i++) d[i] = 32'(i + 1);
    do_write(32'h100, 4'd3, 4'd1, d, s, 16'h0008, 1'b0);
    chk("t2_model_pin", model[64], 32'd1);
    do_read(32'h100, 4'd3, 4'd2, 0, cyc);
    for (int i = 0; i < 4; i++) begin
      chk("t2_rdata", got[i].data, 32'(i + 1));
      chk("t2_rlast", 32'(got[i].last), 32'(i == 3));
    end
    chk("t2_cycles", 32'(cyc), 32'd4);

    // same burst with rready toggling
    do_read(32'h100, 4'd3, 4'd4, 1, cyc);
    for (int i = 0; i < 4; i++) chk("t3_rdata", got[i].data, 32'(i + 1));
    chk("t3_cycles", 32'(cyc), 32'd7);

    // byte-lane write
    d[0] = 32'h11223344;
    do_write(32'h200, 4'd0, 4'd6, d, s, 16'h0001, 1'b0);
    d[0] = 32'h0000AB00; s[0] = 4'b0010;
    do_write(32'h200, 4'd0, 4'd6, d, s, 16'h0001, 1'b0);
    s[0] = 4'hF;
    do_read(32'h200, 4'd0, 4'd6, 0, cyc);
    chk("t4_strb", got[0].data, 32'h1122AB44);

    // early wlast: both beats still written, SLVERR
    d[0] = 32'hA5A50001; d[1] = 32'hA5A50002;
    do_write(32'h300, 4'd1, 4'd9, d, s, 16'h0003, 1'b0);
    chk("t5_bresp", 32'(got_b[$].resp), 32'd2);
    chk("t5_bid", 32'(got_b[$].id), 32'd9);
    do_read(32'h300, 4'd1, 4'd0, 0, cyc);
    chk("t5_beat0", got[0].data, 32'hA5A50001);
    chk("t5_beat1", got[1].data, 32'hA5A50002);

    // address aliasing: 0x1000 maps onto word 0
    d[0] = 32'hCAFE0000;
    do_write(32'h0, 4'd0, 4'd2, d, s, 16'h0001, 1'b0);
    do_read(32'h1000, 4'd0, 4'd8, 0, cyc);
    chk("t6_alias", got[0].data, 32'hCAFE0000);

    // reset in the middle of a stalled read burst
    for (int i = 0; i < 4; i++) exp_r.push_back('{data: model[64 + i], id: 4'd7, last: (i == 3)});
    araddr = 32'h100; arid = 4'd7; arlen = 4'd3; arvalid = 1'b1; rready = 1'b0;
    cyc = 0;
    while (!arready && cyc < 50) begin @(posedge aclk); #1; cyc++; end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    @(posedge aclk); #1;
    chk("t7_pre_rvalid", 32'(rvalid), 32'd1);
    areset = 1'b1;
    #1;
    chk("t7_rvalid_drop", 32'(rvalid), 32'd0);
    chk("t7_rlast_drop", 32'(rlast), 32'd0);
    chk("t7_arready_drop", 32'(arready), 32'd0);
    exp_r.delete();
    @(posedge aclk); #1;
    areset = 1'b0;
    chk("t7_arready_low", 32'(arready), 32'd0);
    @(posedge aclk); #1;
    chk("t7_arready_high", 32'(arready), 32'd1);
    do_read(32'h100, 4'd3, 4'd7, 0, cyc);
    for (int i = 0; i < 4; i++) chk("t7_rdata", got[i].data, 32'(i + 1));

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [31:0] r;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [15:0] lastm;
      int          w;
      r = $urandom;
      len = 4'($urandom_range(0, 7));
      w = ($urandom_range(0, 7) == 0) ? 1020 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
      addr = {r[31:12], 10'(w), r[1:0]};
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          d[i] = $urandom;
          s[i] = 4'($urandom);
        end
        lastm = ($urandom_range(0, 5) == 0) ? 16'($urandom) : (16'd1 << len);
        do_write(addr, len, 4'($urandom), d, s, lastm, 1'b1);
      end else begin
        do_read(addr, len, 4'($urandom), 2, cyc);
      end
    end
    for (int i = 0; i < 16; i++) s[i] = 4'hF;

    repeat (3) begin @(posedge aclk); #1; end
    chk("final_r_queue_empty", 32'(exp_r.size()), 32'd0);
    chk("final_b_queue_empty", 32'(exp_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word-address width; memory holds 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter INIT_ZERO, default 1: 1 means the memory powers up cleared to 0 (simulation only).
REQ-003 SHALL have port aclk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port areset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have inputs arid[3:0], araddr[31:0], arlen[3:0], arsize[2:0], arburst[1:0], arvalid and output arready[1]: the AXI3 read address channel.
REQ-006 SHALL have outputs rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid and input rready: the AXI3 read data channel.
REQ-007 SHALL have inputs awid[3:0], awaddr[31:0], awlen[3:0], awsize[2:0], awburst[1:0], awvalid and output awready: the AXI3 write address channel.
REQ-008 SHALL have inputs wid[3:0], wdata[31:0], wstrb[3:0], wlast, wvalid and output wready: the AXI3 write data channel.
REQ-009 SHALL have outputs bid[3:0], bresp[1:0], bvalid and input bready: the AXI3 write response channel.
REQ-010 SHALL ignore arlock/arcache/arprot/awlock/awcache/awprot; these ports are absent.

Function
REQ-011 SHALL run read and write as independent FSMs; each holds one outstanding transaction.
REQ-012 SHALL use word index = addr[ADDR_W+1:2]; upper address bits ignored (aliased), addr[1:0] ignored.
REQ-013 SHALL treat all bursts as INCR of arlen+1 / awlen+1 beats, 4 bytes/beat, regardless of size/burst fields; word index wraps modulo 2^ADDR_W.
REQ-014 SHALL implement read FSM states R_IDLE (arready=1), R_DATA (rvalid=1).
REQ-015 SHALL, on AR handshake in R_IDLE: latch arid and arlen, issue a RAM read of the word index, load beat counter 0, go to R_DATA.
REQ-016 SHALL assert rvalid the cycle after the AR handshake; rdata = RAM output; rid = latched ID; rresp = 2'b00; rlast = (counter == latched len).
REQ-017 SHALL hold rdata/rlast stable while rvalid & !rready; the RAM read enable is off.
REQ-018 SHALL, on R handshake with !rlast: read the next index in the same cycle and increment the counter; back-to-back beats at 1 beat/cycle.
REQ-019 SHALL, on R handshake with rlast: go to R_IDLE; arready=1 next cycle.
REQ-020 SHALL implement write FSM states W_IDLE (awready=1, wready=0), W_DATA (wready=1), W_RESP (bvalid=1).
REQ-021 SHALL, on AW handshake: latch awid, awlen and index; clear the counter and the error flag; go to W_DATA. No W beat is accepted before the AW handshake.
REQ-022 SHALL, per W handshake: write the enabled bytes of wdata per wstrb to the current index and increment index/counter.
REQ-023 SHALL set the error flag if wlast=1 on a non-final beat or wlast=0 on the final beat; the beat count is governed by awlen only.
REQ-024 SHALL, after the final beat, go to W_RESP: bid = latched ID, bresp = 2'b10 (SLVERR) if error flag else 2'b00; hold until bready, then W_IDLE.
REQ-025 SHALL, for a same-cycle read and write to the same word, return the old data to the read (read-first).
REQ-026 SHALL ignore wid (AXI3 write interleaving unsupported); bid comes from awid.

Reset
REQ-027 SHALL, while areset=1, force the FSMs to R_IDLE/W_IDLE and drive arready, awready, wready, rvalid, bvalid, rlast=0, with rid, bid, rresp, bresp=0.
REQ-028 SHALL register arready/awready; they rise on the first aclk edge after areset falls.
REQ-029 SHALL abandon an in-flight transaction on reset mid-operation, with no response; memory contents are not cleared.

Structure
REQ-030 SHALL put the RESP_OKAY/RESP_SLVERR constants and the FSM state encodings in the shared package axi_pkg.
REQ-031 SHALL use one sub-module, sram_sdp: simple dual-port with 1 synchronous read port (registered output, read enable) and 1 write port with 4 byte enables.

Verification
REQ-032 SHALL check: after reset, AW addr 0x10, len 0, id 5, W 0xDEADBEEF strb 1111 wlast 1 -> bvalid, bid 5, bresp 00; AR addr 0x10 id 3 -> rvalid next cycle, rdata 0xDEADBEEF, rid 3, rlast 1.
REQ-033 SHALL check: write 4-beat burst at 0x100 with 1,2,3,4; read arlen 3, rready tied 1 -> rdata 1,2,3,4 on consecutive cycles, rlast only on the 4th beat.
REQ-034 SHALL check: rready toggled 1010 during the 4-beat read -> rdata held stable while stalled; same 1..4 sequence.
REQ-035 SHALL check: wstrb 0010 writing 0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
REQ-036 SHALL check: awlen 1 with wlast=1 on beat 0 -> both beats written, bresp 10; ADDR_W=10 read at 0x1000 -> returns word at 0x0.
REQ-037 SHALL check: areset asserted mid read burst -> rvalid=0 immediately; arready=1 one cycle after release; a new read returns correct data.
